// File: rtl/note_lane_scroller.sv
// Active note table for the note highway: scrolls every note once per frame, retires notes
// that fall off screen and resolves strums against the hit zone. Optional macro: STREAK_SPEEDUP_EN.
module note_lane_scroller #(
    parameter int NUM_SLOTS  = 8,
    parameter int NUM_LANES  = 5,
    parameter int LANE_X0    = 160,
    parameter int LANE_PITCH = 70,
    parameter int NOTE_W     = 60,
    parameter int NOTE_H     = 16,
    parameter int SPEED      = 2,
    parameter int SCREEN_H   = 480,
    parameter int HIT_Y      = 400,
    parameter int HIT_WIN    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         spawn_valid,
    input  logic [2:0]                   spawn_lane,
    output logic                         spawn_ready,
    input  logic                         strum_valid,
    input  logic [2:0]                   strum_lane,
    output logic                         hit_pulse,
    output logic                         miss_pulse,
    input  logic [$clog2(NUM_SLOTS)-1:0] rd_slot,
    output logic                         rd_valid,
    output logic [9:0]                   rd_x,
    output logic [9:0]                   rd_y,
    output logic [9:0]                   rd_w,
    output logic [9:0]                   rd_h,
    output logic                         busy,
    output logic [15:0]                  hit_count,
    output logic [15:0]                  miss_count
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SCROLL = 1'b1;

    logic [0:0]           state_reg;
    logic [SLOT_W-1:0]    idx_reg;
    logic [NUM_SLOTS-1:0] valid_reg;
    logic [2:0]           lane_reg [NUM_SLOTS];
    logic [9:0]           y_reg    [NUM_SLOTS];
    logic                 hit_pulse_reg;
    logic                 miss_pulse_reg;
    logic [15:0]          hit_count_reg;
    logic [15:0]          miss_count_reg;
    logic [3:0]           speed;

    logic [NUM_SLOTS-1:0] free_vec;
    logic [NUM_SLOTS-1:0] match_vec;
    logic [SLOT_W-1:0]    spawn_idx;
    logic [SLOT_W-1:0]    match_idx;
    logic                 spawn_found;
    logic                 match_found;
    logic                 in_idle;
    logic                 do_spawn;
    logic                 do_hit;
    logic                 do_strum_miss;
    logic                 do_advance;
    logic                 do_retire;
    logic [10:0]          y_next;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign free_vec[gi]  = ~valid_reg[gi];
            assign match_vec[gi] = valid_reg[gi] && (lane_reg[gi] == strum_lane)
                                   && (int'(y_reg[gi]) >= HIT_Y - HIT_WIN)
                                   && (int'(y_reg[gi]) <= HIT_Y + HIT_WIN);
        end
    endgenerate

    // Scanning downward leaves the lowest matching index as the winner.
    always_comb begin
        spawn_idx   = '0;
        spawn_found = 1'b0;
        match_idx   = '0;
        match_found = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                spawn_idx   = SLOT_W'(i);
                spawn_found = 1'b1;
            end
            if (match_vec[i]) begin
                match_idx   = SLOT_W'(i);
                match_found = 1'b1;
            end
        end
    end

    assign in_idle       = (state_reg == ST_IDLE);
    assign spawn_ready   = in_idle && spawn_found;
    assign do_spawn      = spawn_valid && spawn_ready && (int'(spawn_lane) < NUM_LANES);
    assign do_hit        = in_idle && strum_valid && match_found;
    assign do_strum_miss = in_idle && strum_valid && !match_found;
    assign y_next        = {1'b0, y_reg[idx_reg]} + {7'b0, speed};
    assign do_advance    = !in_idle && valid_reg[idx_reg];
    assign do_retire     = do_advance && (y_next >= 11'(SCREEN_H));

    // Spawn targets a free slot and a hit targets a valid one, so both valid writes can coexist.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            valid_reg      <= '0;
            hit_pulse_reg  <= 1'b0;
            miss_pulse_reg <= 1'b0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            hit_pulse_reg  <= do_hit;
            miss_pulse_reg <= do_strum_miss || do_retire;
            if (do_hit && hit_count_reg != 16'hFFFF)
                hit_count_reg <= hit_count_reg + 16'd1;
            if ((do_strum_miss || do_retire) && miss_count_reg != 16'hFFFF)
                miss_count_reg <= miss_count_reg + 16'd1;
            if (do_spawn)
                valid_reg[spawn_idx] <= 1'b1;
            if (do_hit)
                valid_reg[match_idx] <= 1'b0;
            if (do_retire)
                valid_reg[idx_reg] <= 1'b0;
            if (in_idle) begin
                if (frame_tick) begin
                    state_reg <= ST_SCROLL;
                    idx_reg   <= '0;
                end
            end else if (idx_reg == SLOT_W'(NUM_SLOTS - 1)) begin
                state_reg <= ST_IDLE;
            end else begin
                idx_reg <= idx_reg + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_spawn) begin
            lane_reg[spawn_idx] <= spawn_lane;
            y_reg[spawn_idx]    <= '0;
        end
        if (do_advance && !do_retire)
            y_reg[idx_reg] <= y_next[9:0];
    end

`ifdef STREAK_SPEEDUP_EN
    logic [3:0] streak_reg;
    logic [3:0] speed_reg;

    // Every 16th consecutive hit bumps the speed; any miss snaps back to the base speed.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_reg <= '0;
            speed_reg  <= 4'(SPEED);
        end else if (do_strum_miss || do_retire) begin
            streak_reg <= '0;
            speed_reg  <= 4'(SPEED);
        end else if (do_hit) begin
            streak_reg <= streak_reg + 4'd1;
            if (streak_reg == 4'hF && speed_reg < 4'd8)
                speed_reg <= speed_reg + 4'd1;
        end
    end

    assign speed = speed_reg;
`else
    assign speed = 4'(SPEED);
`endif

    assign rd_valid   = valid_reg[rd_slot];
    assign rd_y       = y_reg[rd_slot];
    assign rd_x       = 10'(LANE_X0 + int'(lane_reg[rd_slot]) * LANE_PITCH);
    assign rd_w       = 10'(NOTE_W);
    assign rd_h       = 10'(NOTE_H);
    assign busy       = (state_reg == ST_SCROLL);
    assign hit_pulse  = hit_pulse_reg;
    assign miss_pulse = miss_pulse_reg;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
endmodule

// File: doc/note_lane_scroller.md
Name: note_lane_scroller

Overview:
- Holds the set of active falling notes for the note highway. Advances every note once per video frame and retires notes that fall off screen.
- Resolves strum hit attempts against a fixed hit zone and reports hits and misses.
- Sits directly upstream of the per-pixel note bounds checker. It drives note x/y and width/height for the slot selected by the pixel renderer.

Parameters:
- NUM_SLOTS, 8, number of concurrent note slots (power of 2, 2..16)
- NUM_LANES, 5, number of lanes
- LANE_X0, 160, x of lane 0 left edge (pixels)
- LANE_PITCH, 70, x distance between lane left edges
- NOTE_W, 60, note width (pixels)
- NOTE_H, 16, note height (pixels)
- SPEED, 2, base pixels moved per frame (1..15)
- SCREEN_H, 480, visible lines; notes retire at or past this y
- HIT_Y, 400, centre line of hit zone
- HIT_WIN, 16, half-width of hit zone (pixels)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- spawn_valid  in  1  request a new note at top of lane
- spawn_lane  in  3  lane for spawn (0..NUM_LANES-1)
- spawn_ready  out  1  spawn accepted when valid && ready
- strum_valid  in  1  one-cycle hit attempt
- strum_lane  in  3  lane of hit attempt
- hit_pulse  out  1  one-cycle: strum matched a note
- miss_pulse  out  1  one-cycle: strum unmatched or note retired
- rd_slot  in  $clog2(NUM_SLOTS)  slot selected by renderer
- rd_valid  out  1  selected slot active (comb.)
- rd_x  out  10  selected note x (comb.)
- rd_y  out  10  selected note y (comb.)
- rd_w  out  10  NOTE_W constant
- rd_h  out  10  NOTE_H constant
- busy  out  1  scroll walk in progress
- hit_count  out  16  saturating hit total
- miss_count  out  16  saturating miss total

Behaviour:
- Reset: all slots invalid; FSM in IDLE. hit_pulse, miss_pulse, busy and both counts are 0. spawn_ready is 1 after reset releases.
- Slot state: valid bit, lane (3b), y (10b). Stored y is always < SCREEN_H.
- rd_x = LANE_X0 + lane*LANE_PITCH. rd_x/rd_y are combinational from rd_slot. rd_x/rd_y are don't-care when rd_valid=0.
- FSM states:
  - IDLE: accepts spawn and strum. frame_tick moves to SCROLL with idx=0 and busy=1.
  - SCROLL: one slot per cycle. For a valid slot, new y = y + speed, computed 11-bit. If new y >= SCREEN_H, clear valid and pulse miss. After idx NUM_SLOTS-1, return to IDLE with busy=0. A walk takes exactly NUM_SLOTS cycles.
- frame_tick while in SCROLL is ignored (no queueing).
- spawn_ready = (state==IDLE) && any slot free. Spawn writes the lowest-index free slot with y=0 and the given lane.
- spawn_lane >= NUM_LANES is accepted but the note is dropped; no slot is used.
- Strum, in IDLE only: pick the lowest-index valid slot with matching lane and HIT_Y-HIT_WIN <= y <= HIT_Y+HIT_WIN.
  - Match found: clear that slot; hit_pulse next cycle.
  - No match: miss_pulse next cycle.
- strum_valid during SCROLL is dropped silently.
- Spawn and strum in the same IDLE cycle:
  - Both are performed.
  - The spawn uses the free map from before the strum, so a slot cleared by that strum is not reused that cycle.
- Spawn and frame_tick in the same cycle: the spawn is written first. The walk then scrolls the new note, giving y=speed after the walk.
- A retire miss and a strum miss cannot coincide; the FSM states are exclusive.
- hit_pulse and miss_pulse are registered, one cycle wide. Each pulse increments its count; counts saturate at 16'hFFFF.
- Reset asserted mid-walk returns to IDLE and invalidates all slots the next cycle.

Optional Feature:
- Macro STREAK_SPEEDUP_EN.
- Defined:
  - A 4-bit hit-streak counter increments on each hit and clears on any miss.
  - Each time it wraps from 15 to 0, effective speed increases by 1, up to a maximum of 8.
  - Any miss restores speed to SPEED.
  - Reset restores SPEED.
- Undefined: effective speed is always SPEED. No streak logic is synthesized.

Test Plan:
- Reset, then spawn lane 2 -> slot 0 valid; rd_slot=0 gives rd_x=300, rd_y=0; spawn_ready=1.
- One note, 200 frame_ticks -> rd_y=400. Strum lane 2 -> hit_pulse once, hit_count=1, slot 0 invalid.
- One note, 240 frame_ticks -> invalid at the 240th walk (y would be 480); miss_pulse once; miss_count=1.
- Fill 8 slots -> spawn_ready=0. Strum a matching note while spawn_valid=1 -> hit, spawn still stalled that cycle, accepted the next cycle.
- Note at y=370, strum lane 2 -> miss_pulse, note unchanged. Strum lane 1 with note at y=400 in lane 2 -> miss_pulse.
- frame_tick held high for 3 cycles -> single walk; busy high exactly 8 cycles. Reset pulsed mid-walk -> all rd_valid=0.
